// File: rtl/avl_pkg.sv
// avl_pkg: shared definitions for the Avalon-MM burst responder.
//   AVL_BC_W / AVL_MAX_BURST : burstcount port width and largest legal burst
//   avl_rd_cmd_t              : queued read command {index, count}
//   avl_wr_state_e / avl_rd_state_e : write and read FSM state encodings
//   avl_eff_count / avl_bc_illegal  : burstcount sanitising helpers
package avl_pkg;

  localparam int AVL_BC_W      = 7;
  localparam int AVL_MAX_BURST = 64;
  // Index field is kept wide so the typedef does not depend on MEM_DEPTH;
  // users take the low log2(MEM_DEPTH) bits.
  localparam int AVL_IDX_W     = 32;

  localparam logic [AVL_BC_W-1:0] AVL_BC_ONE = AVL_BC_W'(1);
  localparam logic [AVL_BC_W-1:0] AVL_BC_MAX = AVL_BC_W'(AVL_MAX_BURST);

  typedef enum logic {WR_IDLE, WR_BURST} avl_wr_state_e;
  typedef enum logic {RD_IDLE, RD_STREAM} avl_rd_state_e;

  typedef struct packed {
    logic [AVL_IDX_W-1:0] index;
    logic [AVL_BC_W-1:0]  count;
  } avl_rd_cmd_t;

  // 0 behaves as a single beat; anything above the maximum is clamped.
  function automatic logic [AVL_BC_W-1:0] avl_eff_count(input logic [AVL_BC_W-1:0] bc);
    if (bc == '0) return AVL_BC_ONE;
    else if (bc > AVL_BC_MAX) return AVL_BC_MAX;
    else return bc;
  endfunction

  function automatic logic avl_bc_illegal(input logic [AVL_BC_W-1:0] bc);
    return (bc == '0) || (bc > AVL_BC_MAX);
  endfunction

endpackage

// File: rtl/avl_burst_rsp_if.sv
// avl_burst_rsp_if: Avalon-MM burst port between the combiner (master) and
// the responder (slave).
//   master drives : s_address, s_read, s_write, s_writedata, s_be, s_burstcount
//   slave drives  : s_waitrequest, s_readdata, s_readdatavalid
// ADDR_WIDTH / DATA_WIDTH must match the parameters of the attached modules.
interface avl_burst_rsp_if
  import avl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0]   s_address;
  logic                    s_read;
  logic                    s_write;
  logic [DATA_WIDTH-1:0]   s_writedata;
  logic [DATA_WIDTH/8-1:0] s_be;
  logic [AVL_BC_W-1:0]     s_burstcount;
  logic                    s_waitrequest;
  logic [DATA_WIDTH-1:0]   s_readdata;
  logic                    s_readdatavalid;

  modport master (
    output s_address, s_read, s_write, s_writedata, s_be, s_burstcount,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_be, s_burstcount,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/avl_cmd_fifo.sv
// avl_cmd_fifo: synchronous FIFO of read commands.
//   clk, rstn       : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : enqueue; accepted when not full, or when full and popping
//   pop             : dequeue the head (ignored when empty)
//   head            : current head entry (valid when ~empty)
//   full, empty     : occupancy flags
module avl_cmd_fifo
  import avl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  avl_rd_cmd_t push_data,
  input  logic        pop,
  output avl_rd_cmd_t head,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  avl_rd_cmd_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_ONE;
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_ONE;
    end
  end
endmodule

// File: rtl/avl_burst_rsp.sv
// avl_burst_rsp: Avalon-MM burst responder backed by a byte-enabled
// simple-dual-port RAM.
//   clk, rstn    : clock, synchronous active-low reset (RAM contents kept)
//   bus          : avl_burst_rsp_if.slave port (requests in, read beats out)
//   protocol_err : sticky flag for illegal burstcount or read+write together
// Optional feature: define AVL_RSP_RANDOM_WAIT_EN to add LFSR-driven stalls
// on s_waitrequest and bubbles between read beats.
module avl_burst_rsp
  import avl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int MEM_DEPTH  = 1024,
  parameter int CMD_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rstn,
  avl_burst_rsp_if.slave bus,
  output logic           protocol_err
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  avl_wr_state_e  wr_state_reg, wr_state_next;
  avl_rd_state_e  rd_state_reg, rd_state_next;
  logic [IDX_W-1:0]    wr_idx_reg, wr_idx_next, rd_idx_reg, rd_idx_next;
  logic [AVL_BC_W-1:0] wr_left_reg, wr_left_next, rd_left_reg, rd_left_next;

  logic ready_reg, rvalid_reg, err_reg;
  logic rand_stall, rd_bubble, wait_c, waitreq;
  logic is_wr, is_rd, wr_acc, rd_acc, first_acc;
  logic [IDX_W-1:0]    first_idx, ram_widx;
  logic [AVL_BC_W-1:0] bc_eff;
  logic ram_we, ram_re;
  logic fifo_pop, fifo_full, fifo_empty;
  avl_rd_cmd_t push_cmd, head_cmd;
  logic [DATA_WIDTH-1:0] rdata_all;
  logic unused_bits;

`ifdef AVL_RSP_RANDOM_WAIT_EN
  logic [15:0] lfsr_reg;
  always_ff @(posedge clk) begin
    if (!rstn) lfsr_reg <= 16'hACE1;
    else       lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end
  assign rand_stall = lfsr_reg[0];
  assign rd_bubble  = lfsr_reg[1];
`else
  assign rand_stall = 1'b0;
  assign rd_bubble  = 1'b0;
`endif

  // Read+write together is handled as a write; the read half is dropped.
  assign is_wr     = bus.s_write;
  assign is_rd     = bus.s_read & ~bus.s_write;
  assign first_idx = bus.s_address[IDX_W-1:0];
  assign bc_eff    = avl_eff_count(bus.s_burstcount);
  assign unused_bits = ^{bus.s_address, head_cmd.index};

  // Writes wait until every queued or streaming read has finished, so a read
  // never observes a write issued after it.
  always_comb begin
    wait_c = 1'b0;
    if (wr_state_reg == WR_BURST) wait_c = is_rd;
    else if (is_wr)               wait_c = ~(fifo_empty & (rd_state_reg == RD_IDLE));
    else if (is_rd)               wait_c = fifo_full;
  end

  assign waitreq           = ~rstn | ~ready_reg | rand_stall | wait_c;
  assign bus.s_waitrequest = waitreq;
  assign wr_acc    = is_wr & ~waitreq;
  assign rd_acc    = is_rd & ~waitreq;
  assign first_acc = rd_acc | (wr_acc & (wr_state_reg == WR_IDLE));
  assign push_cmd  = '{index: AVL_IDX_W'(first_idx), count: bc_eff};

  // Write FSM: the RAM write happens on the edge that accepts the beat.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_idx_next   = wr_idx_reg;
    wr_left_next  = wr_left_reg;
    ram_we        = 1'b0;
    ram_widx      = wr_idx_reg;
    if (wr_acc) begin
      ram_we = 1'b1;
      if (wr_state_reg == WR_IDLE) begin
        ram_widx     = first_idx;
        wr_idx_next  = first_idx + IDX_ONE;
        wr_left_next = bc_eff - AVL_BC_ONE;
        if (bc_eff > AVL_BC_ONE) wr_state_next = WR_BURST;
      end else begin
        wr_idx_next  = wr_idx_reg + IDX_ONE;
        wr_left_next = wr_left_reg - AVL_BC_ONE;
        if (wr_left_reg == AVL_BC_ONE) wr_state_next = WR_IDLE;
      end
    end
  end

  // Read engine: on the last beat of a burst the next command is popped in
  // the same cycle so consecutive bursts stream without a gap.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_idx_next   = rd_idx_reg;
    rd_left_next  = rd_left_reg;
    fifo_pop      = 1'b0;
    ram_re        = 1'b0;
    unique case (rd_state_reg)
      RD_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          rd_idx_next   = head_cmd.index[IDX_W-1:0];
          rd_left_next  = head_cmd.count;
          rd_state_next = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (!rd_bubble) begin
          ram_re       = 1'b1;
          rd_idx_next  = rd_idx_reg + IDX_ONE;
          rd_left_next = rd_left_reg - AVL_BC_ONE;
          if (rd_left_reg == AVL_BC_ONE) begin
            if (!fifo_empty) begin
              fifo_pop     = 1'b1;
              rd_idx_next  = head_cmd.index[IDX_W-1:0];
              rd_left_next = head_cmd.count;
            end else begin
              rd_state_next = RD_IDLE;
            end
          end
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_reg    <= 1'b0;
      wr_state_reg <= WR_IDLE;
      wr_idx_reg   <= '0;
      wr_left_reg  <= '0;
      rd_state_reg <= RD_IDLE;
      rd_idx_reg   <= '0;
      rd_left_reg  <= '0;
      rvalid_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      ready_reg    <= 1'b1;
      wr_state_reg <= wr_state_next;
      wr_idx_reg   <= wr_idx_next;
      wr_left_reg  <= wr_left_next;
      rd_state_reg <= rd_state_next;
      rd_idx_reg   <= rd_idx_next;
      rd_left_reg  <= rd_left_next;
      rvalid_reg   <= ram_re;
      if ((wr_acc & bus.s_read) | (first_acc & avl_bc_illegal(bus.s_burstcount)))
        err_reg <= 1'b1;
    end
  end

  avl_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rd_acc),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One byte-wide RAM per lane keeps the byte-enable write simple.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] rdata_lane_reg;
    always_ff @(posedge clk) begin
      if (ram_we && bus.s_be[gi]) mem[ram_widx] <= bus.s_writedata[gi*8 +: 8];
    end
    always_ff @(posedge clk) begin
      if (!rstn)       rdata_lane_reg <= 8'h00;
      else if (ram_re) rdata_lane_reg <= mem[rd_idx_reg];
    end
    assign rdata_all[gi*8 +: 8] = rdata_lane_reg;
  end

  assign bus.s_readdata      = rdata_all;
  assign bus.s_readdatavalid = rvalid_reg;
  assign protocol_err        = err_reg;
endmodule

// File: tb/tb_avl_burst_rsp.sv
module tb_avl_burst_rsp;
  import avl_pkg::*;

  localparam int AW = 32, DW = 512, DEPTH = 1024, CMDD = 4, NB = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic protocol_err;
  int   cycle = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            valid_cycles [$];
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] mon_exp;

  avl_burst_rsp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  avl_burst_rsp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .CMD_DEPTH(CMDD)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every returned beat is matched against the queue head.
  always @(negedge clk) begin
    if (bus.s_readdatavalid === 1'b1) begin
      valid_cycles.push_back(cycle);
      last_rdata = bus.s_readdata;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: readdatavalid=1 at cycle %0d, required no beat", cycle);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.s_readdata !== mon_exp)
          $display("FAIL read_data at cycle %0d: got %h required %h", cycle, bus.s_readdata, mon_exp);
        else
          pass_cnt++;
      end
    end
  end

  function automatic int widx(input logic [31:0] a, input int n);
    return (int'(a % 32'(DEPTH)) + n) % DEPTH;
  endfunction

  task automatic wait_accept(output int stalls, output bit ok);
    stalls = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_waitrequest === 1'b0) break;
      stalls++;
      if (stalls > 300) begin
        chk_cnt++;
        $display("FAIL accept_timeout: waitrequest=%b after %0d cycles, required 0", bus.s_waitrequest, stalls);
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [6:0] bc, input int nbeats,
                          input logic [DW-1:0] base, input logic [NB-1:0] be, input bit with_read);
    int st;
    bit ok;
    for (int n = 0; n < nbeats; n++) begin
      bus.s_write = 1'b1;
      bus.s_read = with_read;
      bus.s_address = addr;
      bus.s_burstcount = bc;
      bus.s_writedata = base + DW'(n);
      bus.s_be = be;
      wait_accept(st, ok);
      if (ok)
        for (int b = 0; b < NB; b++)
          if (be[b]) model_mem[widx(addr, n)][b*8 +: 8] = bus.s_writedata[b*8 +: 8];
    end
    bus.s_write = 1'b0;
    bus.s_read = 1'b0;
    $display("tb: write addr=%0d bc=%0d beats=%0d be=%h rd=%0b", addr, bc, nbeats, be, with_read);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [6:0] bc, output int acc, output int stalls);
    bit ok;
    int eff;
    bus.s_read = 1'b1;
    bus.s_address = addr;
    bus.s_burstcount = bc;
    wait_accept(stalls, ok);
    bus.s_read = 1'b0;
    acc = cycle;
    eff = (bc == 0) ? 1 : ((bc > 64) ? 64 : int'(bc));
    if (ok)
      for (int n = 0; n < eff; n++) exp_q.push_back(model_mem[widx(addr, n)]);
    $display("tb: read addr=%0d bc=%0d accepted_cycle=%0d stalls=%0d", addr, bc, acc, stalls);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    else
      pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.s_waitrequest !== 1'b1) $display("FAIL rst_waitreq: got %b required 1", bus.s_waitrequest); else pass_cnt++;
    chk_cnt++; if (bus.s_readdatavalid !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.s_readdatavalid); else pass_cnt++;
    chk_cnt++; if (bus.s_readdata !== '0) $display("FAIL rst_rdata: got %h required 0", bus.s_readdata); else pass_cnt++;
    chk_cnt++; if (protocol_err !== 1'b0) $display("FAIL rst_err: got %b required 0", protocol_err); else pass_cnt++;
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.s_waitrequest !== 1'b1) $display("FAIL rst_release_wait: got %b required 1", bus.s_waitrequest); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.s_waitrequest !== 1'b0) $display("FAIL rst_ready: got %b required 0", bus.s_waitrequest); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int acc, st;
    do_write(5, 1, 1, {NB{8'hA5}}, '1, 1'b0);
    valid_cycles.delete();
    do_read(5, 1, acc, st);
    wait_drain();
    chk_cnt++;
    if (valid_cycles.size() != 1 || valid_cycles[0] != acc + 2)
      $display("FAIL single_latency: beats=%0d first=%0d required 1 beat at %0d", valid_cycles.size(),
               (valid_cycles.size() > 0) ? valid_cycles[0] : -1, acc + 2);
    else pass_cnt++;
    chk_cnt++;
    if (last_rdata !== {NB{8'hA5}}) $display("FAIL single_data: got %h required all A5", last_rdata); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int acc, st, bad;
    logic [DW-1:0] base;
    base = {16{32'h1234_0000}};
    do_write(DEPTH - 2, 4, 4, base, '1, 1'b0);
    valid_cycles.delete();
    do_read(DEPTH - 2, 4, acc, st);
    wait_drain();
    bad = 0;
    for (int i = 0; i < valid_cycles.size(); i++) if (valid_cycles[i] != acc + 2 + i) bad++;
    chk_cnt++;
    if (valid_cycles.size() != 4 || bad != 0)
      $display("FAIL wrap_timing: beats=%0d off_cycle=%0d required 4 consecutive from %0d", valid_cycles.size(), bad, acc + 2);
    else pass_cnt++;
    do_read(0, 1, acc, st);
    wait_drain();
    chk_cnt++;
    if (last_rdata !== base + DW'(2)) $display("FAIL wrap_idx0: got %h required %h", last_rdata, base + DW'(2)); else pass_cnt++;
    do_read(DEPTH - 2 + 3 * DEPTH, 1, acc, st);
    wait_drain();
    chk_cnt++;
    if (last_rdata !== base) $display("FAIL addr_mod: got %h required %h", last_rdata, base); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc0, acc, st, bad;
    do_write(100, 64, 64, {16{32'hB2B0_0000}}, '1, 1'b0);
    valid_cycles.delete();
    do_read(100, 64, acc0, st);
    for (int i = 1; i <= 5; i++) do_read(100 + 8 * i, 4, acc, st);
    chk_cnt++;
    if (st < 55 || st > 65) $display("FAIL fifo_full_stall: fifth read stalled %0d cycles, required about 61", st); else pass_cnt++;
    wait_drain();
    bad = 0;
    for (int i = 0; i < valid_cycles.size(); i++) if (valid_cycles[i] != acc0 + 2 + i) bad++;
    chk_cnt++;
    if (valid_cycles.size() != 84 || bad != 0)
      $display("FAIL b2b_stream: beats=%0d off_cycle=%0d required 84 consecutive from %0d", valid_cycles.size(), bad, acc0 + 2);
    else pass_cnt++;
  endtask

  task automatic test_partial_be();
    int acc, st;
    logic [DW-1:0] want;
    want = {{(NB-1){8'hFF}}, 8'h00};
    do_write(200, 1, 1, {NB{8'hFF}}, '1, 1'b0);
    do_write(200, 1, 1, '0, NB'(1), 1'b0);
    do_read(200, 1, acc, st);
    wait_drain();
    chk_cnt++;
    if (last_rdata !== want) $display("FAIL partial_be: got %h required %h", last_rdata, want); else pass_cnt++;
  endtask

  task automatic test_protocol_err();
    int acc, st;
    chk_cnt++; if (protocol_err !== 1'b0) $display("FAIL err_clean: got %b required 0", protocol_err); else pass_cnt++;
    do_write(300, 1, 1, {16{32'hC0DE_0300}}, '1, 1'b1);
    @(negedge clk);
    chk_cnt++; if (protocol_err !== 1'b1) $display("FAIL err_rw: got %b required 1", protocol_err); else pass_cnt++;
    @(posedge clk); #1;
    do_write(301, 0, 1, {16{32'hC0DE_0301}}, '1, 1'b0);
    do_write(302, 1, 1, {16{32'hC0DE_0302}}, '1, 1'b0);
    do_read(300, 3, acc, st);
    wait_drain();
    valid_cycles.delete();
    do_read(100, 100, acc, st);
    wait_drain();
    chk_cnt++;
    if (valid_cycles.size() != 64) $display("FAIL clamp_count: beats=%0d required 64", valid_cycles.size()); else pass_cnt++;
    chk_cnt++; if (protocol_err !== 1'b1) $display("FAIL err_sticky: got %b required 1", protocol_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acc, st, n;
    do_write(400, 8, 8, {16{32'h4000_0000}}, '1, 1'b0);
    valid_cycles.delete();
    do_read(400, 8, acc, st);
    n = 0;
    while (valid_cycles.size() < 3 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk_cnt++;
    if (valid_cycles.size() < 3) $display("FAIL mid_beats: got %0d beats required 3", valid_cycles.size()); else pass_cnt++;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.s_readdatavalid !== 1'b0) $display("FAIL mid_valid: got %b required 0", bus.s_readdatavalid); else pass_cnt++;
    chk_cnt++; if (bus.s_readdata !== '0) $display("FAIL mid_rdata: got %h required 0", bus.s_readdata); else pass_cnt++;
    exp_q.delete();
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.s_waitrequest !== 1'b1) $display("FAIL mid_release_wait: got %b required 1", bus.s_waitrequest); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.s_waitrequest !== 1'b0) $display("FAIL mid_ready: got %b required 0", bus.s_waitrequest); else pass_cnt++;
    chk_cnt++; if (protocol_err !== 1'b0) $display("FAIL mid_err_clear: got %b required 0", protocol_err); else pass_cnt++;
    @(posedge clk); #1;
    do_read(403, 2, acc, st);
    wait_drain();
    chk_cnt++;
    if (last_rdata !== {16{32'h4000_0000}} + DW'(4))
      $display("FAIL mid_after: got %h required %h", last_rdata, {16{32'h4000_0000}} + DW'(4));
    else pass_cnt++;
  endtask

  initial begin
    bus.s_address = '0;
    bus.s_read = 1'b0;
    bus.s_write = 1'b0;
    bus.s_writedata = '0;
    bus.s_be = '0;
    bus.s_burstcount = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_partial_be();
    test_protocol_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
